// File: rtl/usb_if_pkg.sv
// ---------------------------------------------------------------------------
// usb_if_pkg
// Shared definitions for the USB test-system producer/consumer blocks.
//   - cons_state_e  : consumer FSM states (IDLE, RUN, DRAIN)
//   - DEF_*         : default data width, packet length, error counter width
//   - PATTERN_START : first value of the incrementing test pattern
//   - LFSR16_TAPS   : Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1
//   - lfsr16_next() : one step of the right-shifting Galois LFSR
// ---------------------------------------------------------------------------
package usb_if_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } cons_state_e;

   localparam int unsigned DEF_DW        = 32;
   localparam int unsigned DEF_PKT_WORDS = 1024;
   localparam int unsigned DEF_ERR_W     = 16;

   localparam int unsigned PATTERN_START = 0;

   // Right-shift Galois form: bit 0 is the output, taps 16,14,13,11 map
   // onto mask bits 15,13,12,10.
   localparam logic [15:0] LFSR16_TAPS   = 16'hB400;
   localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;

   function automatic logic [15:0] lfsr16_next(input logic [15:0] cur);
      lfsr16_next = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR16_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/usb_lfsr16.sv
// ---------------------------------------------------------------------------
// usb_lfsr16
// 16-bit Galois LFSR used to generate pseudo-random read throttling.
// Shared between the smart producer and smart consumer.
// Ports:
//   clk_i    in  1  : clock, rising edge
//   rst_i    in  1  : synchronous active-high reset, loads seed_i
//   en_i     in  1  : advance the LFSR by one step
//   seed_i   in  16 : reset value (must be nonzero)
//   state_o  out 16 : current LFSR state
// ---------------------------------------------------------------------------
module usb_lfsr16
   import usb_if_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic [15:0] seed_i,
   output logic [15:0] state_o
);

   logic [15:0] state_q;
   logic [15:0] state_d;

   // An all-zero state would lock the LFSR forever, so a zero seed is
   // replaced with 1 rather than silently stalling the sequence.
   logic [15:0] seed_safe;
   assign seed_safe = (seed_i == 16'h0000) ? 16'h0001 : seed_i;

   // Next state: step when enabled, otherwise hold.
   always_comb begin
      state_d = state_q;
      if (en_i) begin
         state_d = lfsr16_next(state_q);
      end
   end

   // State register with synchronous seed load on reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= seed_safe;
      end else begin
         state_q <= state_d;
      end
   end

   assign state_o = state_q;

endmodule

// File: rtl/usb_smart_consumer.sv
// ---------------------------------------------------------------------------
// usb_smart_consumer
// Self-checking FIFO sink for the USB test system. Drains fixed-length
// packets from a data FIFO and checks every word against the incrementing
// pattern produced by smartProducer. The expected value persists across
// packets, so packet k expects k*PKT_WORDS .. (k+1)*PKT_WORDS-1 (mod 2^DW).
//
// Optional feature macro: USB_SMART_CONSUMER_THROTTLE_EN
//   When defined, a 16-bit LFSR withholds reads on ~25% of RUN cycles to
//   exercise upstream backpressure. When undefined there is no LFSR.
//
// Parameters: DW (data width), PKT_WORDS (words per packet, >=1),
//             ERR_W (error counter width), SEED (LFSR seed, throttle only)
// Ports:
//   clk_i          in  1     : clock, rising edge
//   rst_i          in  1     : synchronous active-high reset
//   en_i           in  1     : start request, honoured only in IDLE
//   fifo_dt_i      in  DW    : FIFO read data, valid the cycle after a read
//   fifo_epty_i    in  1     : FIFO empty
//   fifo_rd_o      out 1     : FIFO read strobe
//   busy_o         out 1     : high in RUN and DRAIN
//   done_o         out 1     : one-cycle pulse at packet end
//   word_cnt_o     out 32    : words checked, wrapping
//   err_cnt_o      out ERR_W : mismatching words, saturating
//   err_o          out 1     : sticky first-mismatch flag
//   first_err_dt_o out DW    : data of the first mismatching word
// ---------------------------------------------------------------------------
module usb_smart_consumer
   import usb_if_pkg::*;
#(
   parameter int unsigned DW        = DEF_DW,
   parameter int unsigned PKT_WORDS = DEF_PKT_WORDS,
   parameter int unsigned ERR_W     = DEF_ERR_W,
   parameter logic [15:0] SEED      = DEF_LFSR_SEED
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic [DW-1:0]    fifo_dt_i,
   input  logic             fifo_epty_i,
   output logic             fifo_rd_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [31:0]      word_cnt_o,
   output logic [ERR_W-1:0] err_cnt_o,
   output logic             err_o,
   output logic [DW-1:0]    first_err_dt_o
);

   localparam int unsigned CNT_W = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PKT_WORDS - 1);
   localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

   cons_state_e      state_q, state_d;
   logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
   logic             rd_q, rd_d;
   logic             done_q, done_d;
   logic [DW-1:0]    exp_q, exp_d;
   logic [31:0]      word_cnt_q, word_cnt_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   logic             err_q, err_d;
   logic [DW-1:0]    first_err_dt_q, first_err_dt_d;

   logic             stall;

`ifdef USB_SMART_CONSUMER_THROTTLE_EN
   logic [15:0] lfsr_state;
   logic        unused_lfsr_hi;

   usb_lfsr16 u_lfsr (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (1'b1),
      .seed_i  (SEED),
      .state_o (lfsr_state)
   );

   // Only the two low bits decide the stall; the rest just feed the LFSR.
   assign unused_lfsr_hi = ^lfsr_state[15:2];
   assign stall          = (lfsr_state[1:0] == 2'b00);
`else
   logic unused_seed;

   assign unused_seed = ^SEED;
   assign stall       = 1'b0;
`endif

   // The read strobe is the only combinational input-to-output path; it can
   // never fire while the FIFO reports empty.
   assign fifo_rd_o = (state_q == ST_RUN) && !fifo_epty_i && !stall;

   // Packet sequencing. The read counter tracks reads issued in this packet;
   // the FSM leaves RUN in the same cycle as the final read so no extra read
   // is ever issued. DRAIN lasts exactly one cycle, the cycle in which the
   // last word is compared, and done is registered so it appears together
   // with the return to IDLE.
   always_comb begin
      state_d  = state_q;
      rd_cnt_d = rd_cnt_q;
      done_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (en_i) begin
               state_d  = ST_RUN;
               rd_cnt_d = '0;
            end
         end
         ST_RUN: begin
            if (fifo_rd_o) begin
               if (rd_cnt_q == LAST_IDX) begin
                  state_d  = ST_DRAIN;
                  rd_cnt_d = '0;
               end else begin
                  rd_cnt_d = rd_cnt_q + CNT_W'(1);
               end
            end
         end
         ST_DRAIN: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Word checker. rd_q marks the cycle in which FIFO data is valid. The
   // expected value advances on every checked word, matching or not, so one
   // corrupted word costs exactly one error and the stream stays in step.
   always_comb begin
      rd_d           = fifo_rd_o;
      exp_d          = exp_q;
      word_cnt_d     = word_cnt_q;
      err_cnt_d      = err_cnt_q;
      err_d          = err_q;
      first_err_dt_d = first_err_dt_q;
      if (rd_q) begin
         exp_d      = exp_q + DW'(1);
         word_cnt_d = word_cnt_q + 32'd1;
         if (fifo_dt_i != exp_q) begin
            if (err_cnt_q != ERR_MAX) begin
               err_cnt_d = err_cnt_q + ERR_W'(1);
            end
            if (!err_q) begin
               err_d          = 1'b1;
               first_err_dt_d = fifo_dt_i;
            end
         end
      end
   end

   // All state registers. Clearing rd_q on reset drops a word that was
   // requested just before reset and returns afterwards.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= ST_IDLE;
         rd_cnt_q       <= '0;
         rd_q           <= 1'b0;
         done_q         <= 1'b0;
         exp_q          <= DW'(PATTERN_START);
         word_cnt_q     <= '0;
         err_cnt_q      <= '0;
         err_q          <= 1'b0;
         first_err_dt_q <= '0;
      end else begin
         state_q        <= state_d;
         rd_cnt_q       <= rd_cnt_d;
         rd_q           <= rd_d;
         done_q         <= done_d;
         exp_q          <= exp_d;
         word_cnt_q     <= word_cnt_d;
         err_cnt_q      <= err_cnt_d;
         err_q          <= err_d;
         first_err_dt_q <= first_err_dt_d;
      end
   end

   assign busy_o         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done_o         = done_q;
   assign word_cnt_o     = word_cnt_q;
   assign err_cnt_o      = err_cnt_q;
   assign err_o          = err_q;
   assign first_err_dt_o = first_err_dt_q;

endmodule

// File: tb/tb_usb_smart_consumer.sv
// ---------------------------------------------------------------------------
// tb_usb_smart_consumer
// Bench for usb_smart_consumer. Two instances: the default 32-bit /
// 1024-word configuration fed from a modelled FIFO, and an 8-bit / 300-word
// / 4-bit-error-counter instance that exercises pattern wrap and error
// counter saturation. A word-level reference model derives expected
// counts from the words actually handed to the DUT: the k-th word read
// since reset should equal k mod 2^32.
// ---------------------------------------------------------------------------
module tb_usb_smart_consumer;

   localparam int PKT    = 1024;
   localparam int MEM_SZ = 4096;

   typedef struct {
      int          bad_idx;
      logic [31:0] bad_val;
      int          gate;
      int          n_pkts;
      int          exp_words;
      int          exp_errs;
      logic        exp_err;
      logic [31:0] exp_first;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance signals
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [31:0] fifo_dt = '0;
   logic        fifo_epty;
   logic        fifo_rd;
   logic        busy;
   logic        done;
   logic [31:0] word_cnt;
   logic [15:0] err_cnt;
   logic        err;
   logic [31:0] first_err;

   // Narrow instance signals
   logic        rst2 = 1'b1;
   logic        en2 = 1'b0;
   logic [7:0]  dt2 = '0;
   logic [7:0]  cnt2 = '0;
   logic [7:0]  off2 = '0;
   logic        fifo_rd2;
   logic        busy2;
   logic        done2;
   logic [31:0] word_cnt2;
   logic [3:0]  err_cnt2;
   logic        err2;
   logic [7:0]  first_err2;

   // FIFO model
   logic [31:0] mem [MEM_SZ];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   logic        flush = 1'b0;
   logic        gate = 1'b0;
   int          gate_mode = 0;

   // Reference model
   int          m_words = 0;
   int          m_errs = 0;
   logic        m_err = 1'b0;
   logic [31:0] m_first = '0;

   // Monitors
   int          cyc = 0;
   int          mon_reads = 0;
   int          mon_dones = 0;
   int          mon_viol = 0;
   int          mon_done_cyc = 0;
   int          mon_run = 0;
   int          mon_max_run = 0;
   int          rd_cyc [MEM_SZ];
   int          mon2_dones = 0;

   int          n_cmp = 0;
   int          n_fail = 0;

   vec_t        vec [4];

   usb_smart_consumer dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .en_i           (en),
      .fifo_dt_i      (fifo_dt),
      .fifo_epty_i    (fifo_epty),
      .fifo_rd_o      (fifo_rd),
      .busy_o         (busy),
      .done_o         (done),
      .word_cnt_o     (word_cnt),
      .err_cnt_o      (err_cnt),
      .err_o          (err),
      .first_err_dt_o (first_err)
   );

   usb_smart_consumer #(
      .DW        (8),
      .PKT_WORDS (300),
      .ERR_W     (4)
   ) dut2 (
      .clk_i          (clk),
      .rst_i          (rst2),
      .en_i           (en2),
      .fifo_dt_i      (dt2),
      .fifo_epty_i    (1'b0),
      .fifo_rd_o      (fifo_rd2),
      .busy_o         (busy2),
      .done_o         (done2),
      .word_cnt_o     (word_cnt2),
      .err_cnt_o      (err_cnt2),
      .err_o          (err2),
      .first_err_dt_o (first_err2)
   );

   assign fifo_epty = gate || (rd_ptr == wr_ptr);

   // FIFO pop with one-cycle read latency, plus the word-level model
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (flush) begin
         rd_ptr <= wr_ptr;
      end else if (fifo_rd) begin
         fifo_dt <= mem[rd_ptr % MEM_SZ];
         rd_ptr  <= rd_ptr + 1;
      end
      if (rst) begin
         m_words <= 0;
         m_errs  <= 0;
         m_err   <= 1'b0;
         m_first <= '0;
      end else if (fifo_rd && !flush) begin
         if (mem[rd_ptr % MEM_SZ] != 32'(m_words)) begin
            if (m_errs < 65535) m_errs <= m_errs + 1;
            if (!m_err) begin
               m_err   <= 1'b1;
               m_first <= mem[rd_ptr % MEM_SZ];
            end
         end
         m_words <= m_words + 1;
      end
   end

   // Empty gating: none, toggle every cycle, or random
   always @(negedge clk) begin
      case (gate_mode)
         1:       gate <= ~gate;
         2:       gate <= ($urandom_range(0, 2) == 0);
         default: gate <= 1'b0;
      endcase
   end

   // Narrow instance data source: i-th read returns (i mod 256) + off2
   always @(posedge clk) begin
      if (rst2) begin
         cnt2 <= '0;
      end else if (fifo_rd2) begin
         dt2  <= cnt2 + off2;
         cnt2 <= cnt2 + 8'd1;
      end
   end

   // Read/done monitors
   always @(negedge clk) begin
      if (rst) begin
         mon_reads   = 0;
         mon_dones   = 0;
         mon_viol    = 0;
         mon_run     = 0;
         mon_max_run = 0;
      end else begin
         if (fifo_rd) begin
            if (fifo_epty) mon_viol = mon_viol + 1;
            if (mon_reads < MEM_SZ) rd_cyc[mon_reads] = cyc;
            mon_reads = mon_reads + 1;
            mon_run   = mon_run + 1;
            if (mon_run > mon_max_run) mon_max_run = mon_run;
         end else begin
            mon_run = 0;
         end
         if (done) begin
            mon_dones    = mon_dones + 1;
            mon_done_cyc = cyc;
         end
      end
      if (rst2) begin
         mon2_dones = 0;
      end else if (done2) begin
         mon2_dones = mon2_dones + 1;
      end
   end

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_neg();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      flush = 1'b1;
      en    = 1'b0;
      wait_neg();
      wait_neg();
      rst   = 1'b0;
      flush = 1'b0;
   endtask

   task automatic push_pattern(input int n, input int bad_idx, input logic [31:0] bad_val);
      for (int i = 0; i < n; i++) begin
         mem[wr_ptr % MEM_SZ] = (i == bad_idx) ? bad_val : 32'(i);
         wr_ptr = wr_ptr + 1;
      end
   endtask

   // Hold en high until n_pkts done pulses are seen, dropping it in the
   // done cycle of the last packet so no further packet starts.
   task automatic apply_stimulus(input int n_pkts);
      int seen;
      seen = 0;
      en   = 1'b1;
      for (int c = 0; c < 8000 * n_pkts && seen < n_pkts; c++) begin
         wait_neg();
         if (done) begin
            seen = seen + 1;
            check_output("busy_at_done", {63'd0, busy}, 64'd0);
            if (seen == n_pkts) en = 1'b0;
         end
      end
      en = 1'b0;
      check_output("pkt_done_seen", 64'(seen), 64'(n_pkts));
      wait_neg();
      wait_neg();
   endtask

   task automatic run_narrow(input logic [7:0] offset);
      rst2 = 1'b1;
      off2 = offset;
      wait_neg();
      wait_neg();
      rst2 = 1'b0;
      en2  = 1'b1;
      wait_neg();
      en2  = 1'b0;
      for (int c = 0; c < 4000 && mon2_dones < 1; c++) wait_neg();
      check_output("n_done_seen", 64'(mon2_dones), 64'd1);
      wait_neg();
      wait_neg();
   endtask

   initial begin
      #900000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vec[0] = '{-1, 32'h0,        0, 1, 1024, 0, 1'b0, 32'h0};
      vec[1] = '{ 5, 32'hDEADBEEF, 0, 1, 1024, 1, 1'b1, 32'hDEADBEEF};
      vec[2] = '{-1, 32'h0,        1, 1, 1024, 0, 1'b0, 32'h0};
      vec[3] = '{-1, 32'h0,        0, 2, 2048, 0, 1'b0, 32'h0};

      // Reset state
      wait_neg();
      wait_neg();
      check_output("rst_fifo_rd",   {63'd0, fifo_rd}, 64'd0);
      check_output("rst_busy",      {63'd0, busy},    64'd0);
      check_output("rst_done",      {63'd0, done},    64'd0);
      check_output("rst_word_cnt",  64'(word_cnt),    64'd0);
      check_output("rst_err_cnt",   64'(err_cnt),     64'd0);
      check_output("rst_err",       {63'd0, err},     64'd0);
      check_output("rst_first_err", 64'(first_err),   64'd0);
      check_output("rst2_busy",     {63'd0, busy2},   64'd0);
      rst  = 1'b0;
      rst2 = 1'b0;

      // Table-driven packets
      for (int v = 0; v < 4; v++) begin
         gate_mode = vec[v].gate;
         do_reset();
         push_pattern(vec[v].n_pkts * PKT, vec[v].bad_idx, vec[v].bad_val);
         apply_stimulus(vec[v].n_pkts);
         gate_mode = 0;
         $display("[TB] vector %0d: words=%0d errs=%0d", v, word_cnt, err_cnt);
         check_output("vec_word_cnt",  64'(word_cnt),       64'(vec[v].exp_words));
         check_output("vec_err_cnt",   64'(err_cnt),        64'(vec[v].exp_errs));
         check_output("vec_err",       {63'd0, err},        {63'd0, vec[v].exp_err});
         check_output("vec_first_err", 64'(first_err),      64'(vec[v].exp_first));
         check_output("vec_dones",     64'(mon_dones),      64'(vec[v].n_pkts));
         check_output("vec_reads",     64'(mon_reads),      64'(vec[v].exp_words));
         check_output("vec_rd_empty",  64'(mon_viol),       64'd0);
         check_output("vec_model_err", 64'(err_cnt),        64'(m_errs));
         if (v == 0) begin
            check_output("done_latency", 64'(mon_done_cyc - rd_cyc[PKT-1]), 64'd2);
`ifdef USB_SMART_CONSUMER_THROTTLE_EN
            check_output("throttled_duty", {63'd0, (mon_max_run < PKT)}, 64'd1);
`else
            check_output("back_to_back", 64'(mon_max_run), 64'(PKT));
`endif
         end
         if (v == 3) begin
`ifdef USB_SMART_CONSUMER_THROTTLE_EN
            check_output("pkt_gap", {63'd0, (rd_cyc[PKT] - rd_cyc[PKT-1] >= 3)}, 64'd1);
`else
            check_output("pkt_gap", 64'(rd_cyc[PKT] - rd_cyc[PKT-1]), 64'd3);
`endif
         end
      end

      // Random backpressure and random corruptions against the model
      for (int t = 0; t < 3; t++) begin
         logic [31:0] val;
         gate_mode = 2;
         do_reset();
         for (int i = 0; i < PKT; i++) begin
            val = 32'(i);
            if ($urandom_range(0, 127) == 0) val = val ^ (32'd1 << $urandom_range(0, 31));
            mem[wr_ptr % MEM_SZ] = val;
            wr_ptr = wr_ptr + 1;
         end
         apply_stimulus(1);
         gate_mode = 0;
         check_output("rnd_word_cnt",  64'(word_cnt),  64'(m_words));
         check_output("rnd_err_cnt",   64'(err_cnt),   64'(m_errs));
         check_output("rnd_err",       {63'd0, err},   {63'd0, m_err});
         check_output("rnd_first_err", 64'(first_err), 64'(m_first));
         check_output("rnd_rd_empty",  64'(mon_viol),  64'd0);
      end

      // Reset in the middle of a packet, then a clean restart
      gate_mode = 0;
      do_reset();
      push_pattern(PKT, -1, 32'h0);
      en = 1'b1;
      for (int c = 0; c < 2000 && mon_reads < 100; c++) wait_neg();
      check_output("reads_before_reset", {63'd0, (mon_reads >= 100)}, 64'd1);
      rst   = 1'b1;
      flush = 1'b1;
      en    = 1'b0;
      wait_neg();
      check_output("mid_rst_fifo_rd",   {63'd0, fifo_rd}, 64'd0);
      check_output("mid_rst_busy",      {63'd0, busy},    64'd0);
      check_output("mid_rst_done",      {63'd0, done},    64'd0);
      check_output("mid_rst_word_cnt",  64'(word_cnt),    64'd0);
      check_output("mid_rst_err_cnt",   64'(err_cnt),     64'd0);
      check_output("mid_rst_err",       {63'd0, err},     64'd0);
      check_output("mid_rst_first_err", 64'(first_err),   64'd0);
      rst   = 1'b0;
      flush = 1'b0;
      push_pattern(PKT, -1, 32'h0);
      apply_stimulus(1);
      check_output("restart_word_cnt", 64'(word_cnt), 64'd1024);
      check_output("restart_err_cnt",  64'(err_cnt),  64'd0);
      check_output("restart_err",      {63'd0, err},  64'd0);

      // Narrow instance: 300 words of an 8-bit pattern wrap after 255
      run_narrow(8'd0);
      check_output("n_word_cnt", 64'(word_cnt2), 64'd300);
      check_output("n_err_cnt",  64'(err_cnt2),  64'd0);
      check_output("n_err",      {63'd0, err2},  64'd0);

      // Narrow instance: every word off by 3, counter saturates at 15
      run_narrow(8'd3);
      check_output("n_sat_word_cnt",  64'(word_cnt2),  64'd300);
      check_output("n_sat_err_cnt",   64'(err_cnt2),   64'd15);
      check_output("n_sat_err",       {63'd0, err2},   64'd1);
      check_output("n_sat_first_err", 64'(first_err2), 64'h03);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
